// File: rtl/comb_pingpong_sched_if.sv
// Handshake bundle between the ping/pong combine scheduler and its combine / HARQ-drain engines.
// o_timeout_err exists only when COMB_SCHED_TIMEOUT_EN is defined.
interface comb_pingpong_sched_if;
  logic         i_rdm_slot_start;
  logic [7:0]   i_user_valid_mask;
  logic [127:0] i_users_ncb;
  logic         o_Combine_process_request;
  logic [3:0]   o_Combine_user_index;
  logic         o_PingPong_Indicator_Combine;
  logic         i_current_cb_combine_comp;
  logic         o_SENDHARQ_Data_request;
  logic         o_SENDHARQ_Data_PingPing_Indicator;
  logic [15:0]  o_SENDHARQ_Data_ncb;
  logic         i_SENDHARQ_Data_Comp;
  logic         o_slot_done;
  logic         o_busy;
`ifdef COMB_SCHED_TIMEOUT_EN
  logic         o_timeout_err;
`endif

  modport slave (
`ifdef COMB_SCHED_TIMEOUT_EN
    output o_timeout_err,
`endif
    input  i_rdm_slot_start, i_user_valid_mask, i_users_ncb,
    input  i_current_cb_combine_comp, i_SENDHARQ_Data_Comp,
    output o_Combine_process_request, o_Combine_user_index, o_PingPong_Indicator_Combine,
    output o_SENDHARQ_Data_request, o_SENDHARQ_Data_PingPing_Indicator, o_SENDHARQ_Data_ncb,
    output o_slot_done, o_busy
  );

  modport master (
`ifdef COMB_SCHED_TIMEOUT_EN
    input  o_timeout_err,
`endif
    output i_rdm_slot_start, i_user_valid_mask, i_users_ncb,
    output i_current_cb_combine_comp, i_SENDHARQ_Data_Comp,
    input  o_Combine_process_request, o_Combine_user_index, o_PingPong_Indicator_Combine,
    input  o_SENDHARQ_Data_request, o_SENDHARQ_Data_PingPing_Indicator, o_SENDHARQ_Data_ncb,
    input  o_slot_done, o_busy
  );
endinterface

// File: rtl/comb_pingpong_sched.sv
// Per-slot user scheduler: combines users into ping/pong buffers while the other buffer drains to HARQ.
// Optional watchdog on combine and drain waits is enabled by defining COMB_SCHED_TIMEOUT_EN.
module comb_pingpong_sched #(
  parameter int NUM_USERS      = 8,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rst,
  comb_pingpong_sched_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_REQ, S_BUSY, S_FLUSH, S_DONE} state_e;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_DRAINING} buf_e;

  if (NUM_USERS < 1 || NUM_USERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("comb_pingpong_sched: parameter out of range");
  end

  state_e       state_q, state_d;
  logic [7:0]   pending_q, pending_d;
  logic [127:0] ncb_q;
  logic [3:0]   idx_q, idx_d;
  logic         wr_sel_q, rd_sel_q;
  buf_e         buf_q [2];
  logic [15:0]  tag_q [2];
  logic         harq_req_q, harq_ind_q;
  logic [15:0]  harq_ncb_q;

  logic [7:0]   elig;
  logic [3:0]   low_idx;
  logic         fill_ev, comb_done_ev, comb_abort_ev;
  logic         any_drain, drain_start_ev, drain_done_ev, drain_to;
  logic         busy_to;

  // Users with a zero Ncb or beyond NUM_USERS are never scheduled.
  always_comb begin
    elig    = '0;
    low_idx = '0;
    for (int k = 0; k < 8; k++)
      elig[k] = pending_q[k] && (k < NUM_USERS) && (ncb_q[16*k +: 16] != 16'h0);
    for (int k = 7; k >= 0; k--)
      if (elig[k]) low_idx = 4'(k);
  end

`ifdef COMB_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] busy_cnt_q, drain_cnt_q;
  logic          err_q;
  assign busy_to  = (state_q == S_BUSY) && (busy_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign drain_to = any_drain && (drain_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      busy_cnt_q  <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_cnt_q  <= (state_q == S_BUSY) ? busy_cnt_q + 1'b1 : '0;
      drain_cnt_q <= (any_drain && !drain_done_ev) ? drain_cnt_q + 1'b1 : '0;
      if (comb_abort_ev || drain_to) err_q <= 1'b1;
    end
  end
  assign bus.o_timeout_err = err_q;
`else
  assign busy_to  = 1'b0;
  assign drain_to = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    idx_d         = idx_q;
    fill_ev       = 1'b0;
    comb_done_ev  = 1'b0;
    comb_abort_ev = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.i_rdm_slot_start) begin
          pending_d = bus.i_user_valid_mask;
          state_d   = S_SELECT;
        end
      S_SELECT: begin
        pending_d = elig;
        if (elig == 8'h0) state_d = S_FLUSH;
        else if (buf_q[wr_sel_q] == B_FREE) begin
          idx_d   = low_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        fill_ev = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY:
        if (bus.i_current_cb_combine_comp || busy_to) begin
          comb_done_ev            = bus.i_current_cb_combine_comp;
          comb_abort_ev           = !bus.i_current_cb_combine_comp;
          pending_d[idx_q[2:0]]   = 1'b0;
          state_d                 = S_SELECT;
        end
      S_FLUSH:
        if (buf_q[0] == B_FREE && buf_q[1] == B_FREE) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drain side runs independently; only the buffer at rd_sel can ever be draining.
  assign any_drain      = (buf_q[0] == B_DRAINING) || (buf_q[1] == B_DRAINING);
  assign drain_start_ev = (buf_q[rd_sel_q] == B_READY) && !any_drain;
  assign drain_done_ev  = (buf_q[rd_sel_q] == B_DRAINING) && (bus.i_SENDHARQ_Data_Comp || drain_to);

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      ncb_q      <= '0;
      idx_q      <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      buf_q[0]   <= B_FREE;
      buf_q[1]   <= B_FREE;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      harq_req_q <= 1'b0;
      harq_ind_q <= 1'b0;
      harq_ncb_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      if (state_q == S_IDLE && bus.i_rdm_slot_start) ncb_q <= bus.i_users_ncb;
      // Combine side only touches FREE/FILLING buffers, drain side only READY/DRAINING.
      if (fill_ev) buf_q[wr_sel_q] <= B_FILLING;
      if (comb_done_ev) begin
        buf_q[wr_sel_q] <= B_READY;
        tag_q[wr_sel_q] <= ncb_q[{idx_q[2:0], 4'b0000} +: 16];
        wr_sel_q        <= ~wr_sel_q;
      end
      if (comb_abort_ev) begin
        buf_q[wr_sel_q] <= B_FREE;
        wr_sel_q        <= ~wr_sel_q;
      end
      harq_req_q <= drain_start_ev;
      if (drain_start_ev) begin
        buf_q[rd_sel_q] <= B_DRAINING;
        harq_ind_q      <= rd_sel_q;
        harq_ncb_q      <= tag_q[rd_sel_q];
      end
      if (drain_done_ev) begin
        buf_q[rd_sel_q] <= B_FREE;
        rd_sel_q        <= ~rd_sel_q;
      end
    end
  end

  assign bus.o_Combine_process_request          = (state_q == S_REQ);
  assign bus.o_Combine_user_index               = idx_q;
  assign bus.o_PingPong_Indicator_Combine       = wr_sel_q;
  assign bus.o_SENDHARQ_Data_request            = harq_req_q;
  assign bus.o_SENDHARQ_Data_PingPing_Indicator = harq_ind_q;
  assign bus.o_SENDHARQ_Data_ncb                = harq_ncb_q;
  assign bus.o_slot_done                        = (state_q == S_DONE);
  assign bus.o_busy                             = (state_q != S_IDLE);

endmodule

// File: tb/tb_comb_pingpong_sched.sv
// Directed bench for comb_pingpong_sched: transaction-level buffer model checked every cycle,
// plus hand-computed request/drain/done timings per scenario.
module tb_comb_pingpong_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comb_pingpong_sched_if bus();
  comb_pingpong_sched #(.NUM_USERS(8), .TIMEOUT_CYCLES(4095)) dut (
    .i_core_clk(clk), .i_rx_rst(rst), .bus(bus));

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus / responder state
  logic [15:0] ncb_arr [8];
  int comb_delay = 1, drain_delay = 1, cc_cnt = 0, dc_cnt = 0;
  bit stray_cc = 0, stray_dc = 0;

  // Model: expected order of users and drained Ncbs, buffer occupancy, observed timings
  int          exp_u[$];
  logic [15:0] exp_h[$];
  int          req_rel[$], harq_rel[$];
  int          cyc = 0, start_cyc = 0, done_rel = -1, done_cnt = 0;
  bit          active = 0, comb_out = 0, drain_out = 0, c_was = 0;
  int          comb_idx = 0;
  bit          comb_buf = 0, m_wr = 0, m_rd = 0, d_buf = 0;
  logic [1:0]  m_full = '0, m_ready = '0;
  logic [15:0] m_tag [2];
  logic [15:0] d_ncb = '0;

  // Completion responders: comp pulses D cycles after each observed request
  initial begin
    forever begin
      @(posedge clk); #1;
      bus.i_current_cb_combine_comp = 1'b0;
      bus.i_SENDHARQ_Data_Comp      = 1'b0;
      if (rst) begin
        cc_cnt = 0; dc_cnt = 0;
      end else begin
        if (cc_cnt > 0) begin cc_cnt--; if (cc_cnt == 0) bus.i_current_cb_combine_comp = 1'b1; end
        if (dc_cnt > 0) begin dc_cnt--; if (dc_cnt == 0) bus.i_SENDHARQ_Data_Comp = 1'b1; end
        if (bus.o_Combine_process_request) cc_cnt = comb_delay;
        if (bus.o_SENDHARQ_Data_request)   dc_cnt = drain_delay;
      end
      if (stray_cc) begin bus.i_current_cb_combine_comp = 1'b1; stray_cc = 0; end
      if (stray_dc) begin bus.i_SENDHARQ_Data_Comp = 1'b1; stray_dc = 0; end
    end
  end

  // Compare process
  initial begin
    int e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0; comb_out = 0; drain_out = 0; m_full = '0; m_ready = '0; m_wr = 0; m_rd = 0;
      end else begin
        chk("busy", 32'(bus.o_busy), 32'(active));
        if (comb_out) begin
          chk("comb_idx_hold", 32'(bus.o_Combine_user_index), comb_idx);
          chk("comb_buf_hold", 32'(bus.o_PingPong_Indicator_Combine), 32'(comb_buf));
        end
        c_was = comb_out;
        if (bus.o_Combine_process_request) begin
          chk("req_expected", 32'(exp_u.size() > 0), 32'd1);
          e = (exp_u.size() > 0) ? exp_u.pop_front() : int'(bus.o_Combine_user_index);
          chk("req_user", 32'(bus.o_Combine_user_index), e);
          chk("req_buf", 32'(bus.o_PingPong_Indicator_Combine), 32'(m_wr));
          chk("req_buf_free", 32'(m_full[m_wr]), 32'd0);
          chk("req_overlap", 32'(comb_out), 32'd0);
          comb_out = 1; comb_idx = e & 7; comb_buf = m_wr; m_full[m_wr] = 1'b1;
          req_rel.push_back(cyc - start_cyc);
        end
        if (c_was && bus.i_current_cb_combine_comp) begin
          comb_out = 0; m_ready[comb_buf] = 1'b1; m_tag[comb_buf] = ncb_arr[comb_idx]; m_wr = !m_wr;
        end
        if (drain_out) begin
          chk("harq_ncb_hold", 32'(bus.o_SENDHARQ_Data_ncb), 32'(d_ncb));
          chk("harq_buf_hold", 32'(bus.o_SENDHARQ_Data_PingPing_Indicator), 32'(d_buf));
        end
        if (bus.o_SENDHARQ_Data_request) begin
          chk("harq_overlap", 32'(drain_out), 32'd0);
          chk("harq_buf_ready", 32'(m_ready[m_rd]), 32'd1);
          chk("harq_buf", 32'(bus.o_SENDHARQ_Data_PingPing_Indicator), 32'(m_rd));
          chk("harq_expected", 32'(exp_h.size() > 0), 32'd1);
          if (exp_h.size() > 0) chk("harq_ncb", 32'(bus.o_SENDHARQ_Data_ncb), 32'(exp_h.pop_front()));
          drain_out = 1; d_ncb = m_tag[m_rd]; d_buf = m_rd; m_ready[m_rd] = 1'b0;
          harq_rel.push_back(cyc - start_cyc);
        end
        if (drain_out && bus.i_SENDHARQ_Data_Comp) begin
          drain_out = 0; m_full[d_buf] = 1'b0; m_rd = !m_rd;
        end
        if (bus.o_slot_done) begin
          chk("done_clean", 32'({exp_u.size() != 0, exp_h.size() != 0, m_full, m_ready, comb_out, drain_out}), 32'd0);
          chk("done_in_slot", 32'(active), 32'd1);
          done_cnt++; done_rel = cyc - start_cyc; active = 0;
        end else if (bus.i_rdm_slot_start && !active) begin
          active = 1; start_cyc = cyc;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.i_rdm_slot_start = 1'b1;
    @(posedge clk); #1 bus.i_rdm_slot_start = 1'b0;
  endtask

  task automatic start_slot(input logic [7:0] mask);
    exp_u.delete(); exp_h.delete(); req_rel.delete(); harq_rel.delete(); done_rel = -1;
    for (int k = 0; k < 8; k++) begin
      bus.i_users_ncb[16*k +: 16] = ncb_arr[k];
      if (mask[k] && ncb_arr[k] != 16'h0) begin exp_u.push_back(k); exp_h.push_back(ncb_arr[k]); end
    end
    bus.i_user_valid_mask = mask;
    pulse_start();
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    if (done_cnt == d0) begin
      tests++; fails++;
      $display("FAIL %s: no slot_done within %0d cycles", name, budget);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clr_ncb();
    for (int k = 0; k < 8; k++) ncb_arr[k] = 16'h0;
  endtask

  task automatic chk_rel(input string name, input int q[$], input int idx, input int exp);
    if (idx < q.size()) chk(name, q[idx], exp);
    else begin tests++; fails++; $display("FAIL %s: missing event, expected at %0d", name, exp); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.i_rdm_slot_start = 1'b0; bus.i_user_valid_mask = '0; bus.i_users_ncb = '0;
    bus.i_current_cb_combine_comp = 1'b0; bus.i_SENDHARQ_Data_Comp = 1'b0;
    clr_ncb();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_comb_outs", 32'({bus.o_Combine_process_request, bus.o_Combine_user_index, bus.o_PingPong_Indicator_Combine}), 32'd0);
    chk("rst_harq_outs", 32'({bus.o_SENDHARQ_Data_request, bus.o_SENDHARQ_Data_PingPing_Indicator, bus.o_SENDHARQ_Data_ncb}), 32'd0);
    chk("rst_done_busy", 32'({bus.o_slot_done, bus.o_busy}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // A: two users ping then pong; a stray start mid-slot must be ignored
    ncb_arr[0] = 16'h0400; ncb_arr[2] = 16'h0400; comb_delay = 20; drain_delay = 30;
    start_slot(8'h05);
    repeat (10) @(posedge clk);
    bus.i_user_valid_mask = 8'hFF;
    pulse_start();
    wait_done(200, "A_done");
    chk("A_nreq", req_rel.size(), 2);
    chk_rel("A_req0", req_rel, 0, 2);
    chk_rel("A_req1", req_rel, 1, 24);
    chk_rel("A_harq0", harq_rel, 0, 24);
    chk_rel("A_harq1", harq_rel, 1, 56);
    chk("A_done_rel", done_rel, 88);

    // Stray completions while idle
    @(negedge clk); stray_cc = 1; stray_dc = 1;
    repeat (3) @(negedge clk);
    chk("idle_stray_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;

    // B: drains stalled, third combine waits for ping to free
    clr_ncb(); ncb_arr[0] = 16'h0100; ncb_arr[1] = 16'h0200; ncb_arr[2] = 16'h0300;
    comb_delay = 5; drain_delay = 200;
    start_slot(8'h07);
    wait_done(800, "B_done");
    chk("B_nreq", req_rel.size(), 3);
    chk_rel("B_req1", req_rel, 1, 9);
    chk_rel("B_req2", req_rel, 2, 211);
    chk_rel("B_harq1", harq_rel, 1, 211);
    chk_rel("B_harq2", harq_rel, 2, 413);
    chk("B_done_rel", done_rel, 615);

    // C: user 1 has Ncb 0, only user 3 combined; stray drain comp during REQ
    clr_ncb(); ncb_arr[3] = 16'h0123; comb_delay = 3; drain_delay = 4;
    start_slot(8'h0A);
    @(negedge clk); stray_dc = 1;
    wait_done(100, "C_done");
    chk("C_nreq", req_rel.size(), 1);
    chk_rel("C_req0", req_rel, 0, 2);
    chk_rel("C_harq0", harq_rel, 0, 7);
    chk("C_done_rel", done_rel, 13);

    // D: combine comp and drain comp land in the same cycle
    clr_ncb(); ncb_arr[0] = 16'hAAAA; ncb_arr[1] = 16'h5555; comb_delay = 10; drain_delay = 10;
    start_slot(8'h03);
    wait_done(100, "D_done");
    chk_rel("D_req1", req_rel, 1, 14);
    chk_rel("D_harq0", harq_rel, 0, 14);
    chk_rel("D_harq1", harq_rel, 1, 26);
    chk("D_done_rel", done_rel, 38);

    // E: empty mask and all-zero Ncb mask
    clr_ncb();
    start_slot(8'h00);
    wait_done(20, "E0_done");
    chk("E0_nreq", req_rel.size(), 0);
    chk("E0_done_rel", done_rel, 3);
    start_slot(8'h0F);
    wait_done(20, "E1_done");
    chk("E1_nreq", req_rel.size(), 0);
    chk("E1_done_rel", done_rel, 3);

    // F: reset during BUSY, then a fresh single-user slot
    ncb_arr[0] = 16'h0011; ncb_arr[1] = 16'h0022; comb_delay = 20; drain_delay = 30;
    start_slot(8'h03);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_u.delete(); exp_h.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("F_rst_outs", 32'({bus.o_Combine_process_request, bus.o_SENDHARQ_Data_request, bus.o_slot_done,
                           bus.o_busy, bus.o_PingPong_Indicator_Combine, bus.o_SENDHARQ_Data_ncb}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("F_no_done_on_rst", done_cnt, d0);
    clr_ncb(); ncb_arr[0] = 16'h0055; comb_delay = 4; drain_delay = 4;
    start_slot(8'h01);
    wait_done(60, "F_done");
    chk("F_one_done", done_cnt, d0 + 1);
    chk("F_nreq", req_rel.size(), 1);
    chk_rel("F_req0", req_rel, 0, 2);
    chk("F_no_stale_harq", harq_rel.size(), 1);
    chk_rel("F_harq0", harq_rel, 0, 8);
    chk("F_done_rel", done_rel, 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
